// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and port-owner codes.
package dmem_arb_pkg;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_FORCE = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating count of consecutive denied host-request cycles with terminal-count flag.
module starve_counter #(
  parameter int CW     = 4,
  parameter int TC_VAL = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam logic [CW-1:0] TC = CW'(TC_VAL);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU has fixed priority, a starving host gets a forced slot
// in which the CPU is stalled for one cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4,
  parameter int CW         = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic          cpu_rd,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e    r_state;
  arb_state_e    w_next;
  owner_e        w_owner;
  logic          w_cpu_act;
  logic          w_tc;
  logic          w_cnt_clr;
  logic          w_cnt_inc;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;

  assign w_cpu_act = cpu_we | cpu_rd;

  starve_counter #(
    .CW     (CW),
    .TC_VAL (STARVE_MAX - 1)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_cnt_clr),
    .i_inc (w_cnt_inc),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_ARB;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_owner   = OWN_NONE;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    cpu_stall = 1'b0;
    host_gnt  = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (w_cpu_act) begin
          w_owner = OWN_CPU;
          if (host_req) begin
            w_cnt_inc = 1'b1;
            // Terminal count means this is the last tolerated denial.
            if (w_tc) w_next = ST_FORCE;
          end else begin
            w_cnt_clr = 1'b1;
          end
        end else if (host_req) begin
          w_owner   = OWN_HOST;
          host_gnt  = 1'b1;
          w_cnt_clr = 1'b1;
        end else begin
          w_cnt_clr = 1'b1;
        end
      end
      ST_FORCE: begin
        // The held CPU access re-presents next cycle, so nothing is lost.
        cpu_stall = 1'b1;
        w_cnt_clr = 1'b1;
        w_next    = ST_ARB;
        if (host_req) begin
          w_owner  = OWN_HOST;
          host_gnt = 1'b1;
        end
      end
      default: w_next = ST_ARB;
    endcase
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    case (w_owner)
      OWN_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
      end
      OWN_HOST: begin
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        mem_we    = host_we;
      end
      default: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
      end
    endcase
  end

  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= host_gnt & ~host_we;
      if (host_gnt && !host_we) r_rdata <= mem_rdata;
    end
  end

  assign host_rvalid = r_rvalid;
  assign host_rdata  = r_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the CPU EX stage and a host/debug port, e.g. a loader or monitor that inspects or patches data memory while the core runs.
- The CPU has fixed priority. A starvation counter forces a host slot after a bounded wait; during that slot the arbiter stalls the CPU.
- Sits between the CPU memory outputs (address_DM, data_out_DM, OUT_MW) and the data memory. Data memory read is combinational.

Parameters:
- AW, 8, address width
- DW, 8, data width
- STARVE_MAX, 4, consecutive denied host-request cycles before a forced host slot; legal range 1..15
- CW, 4, starvation counter width; must satisfy 2^CW > STARVE_MAX

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_we  in  1  CPU memory write this cycle (EX_MW)
- cpu_rd  in  1  CPU memory read this cycle (EX MD==01)
- cpu_addr  in  AW  CPU address (EX bus A)
- cpu_wdata  in  DW  CPU write data (EX bus B)
- cpu_rdata  out  DW  read data to the CPU data_mem_reg
- cpu_stall  out  1  forces the CPU pipeline to hold; must be OR'd into the DHS path
- host_req  in  1  host requests one access
- host_we  in  1  host write (1) / read (0)
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host access performed this cycle
- host_rvalid  out  1  host_rdata valid; one cycle after a read grant
- host_rdata  out  DW  registered host read data
- mem_addr  out  AW  to data memory
- mem_wdata  out  DW  to data memory
- mem_we  out  1  to data memory
- mem_rdata  in  DW  from data memory (combinational read)

Behaviour:
- Reset (reset=0, async): FSM goes to ARB, starve_cnt=0. host_rvalid=0, host_rdata=0, cpu_stall=0, host_gnt=0.
- cpu_act = cpu_we | cpu_rd. If both are 1, treat as a write.
- FSM state ARB:
  - cpu_act=1: CPU owns the port. mem_* = cpu_*, host_gnt=0.
  - If host_req is also 1: starve_cnt increments. When starve_cnt reaches STARVE_MAX-1 in this cycle, next state is FORCE.
  - cpu_act=0 and host_req=1: host owns the port, host_gnt=1, starve_cnt resets to 0.
  - Neither active: mem_we=0, mem_addr=cpu_addr.
- FSM state FORCE:
  - cpu_stall=1 (combinational, this cycle only).
  - Host owns the port: host_gnt=host_req, starve_cnt=0.
  - Next state is always ARB.
  - If host_req dropped before FORCE, no host access occurs, mem_we=0 and stall still asserts. This is a legal wasted cycle.
- Dropping host_req in ARB clears starve_cnt to 0 at the next edge.
- cpu_rdata = mem_rdata combinationally in every state. It is meaningless during a stall because the CPU holds.
- host_rvalid=1 and host_rdata=mem_rdata are registered at the edge ending a cycle with host_gnt=1 and host_we=0. Otherwise host_rvalid=0 and host_rdata holds its value.
- The host must hold host_req, host_we, host_addr and host_wdata stable until host_gnt. A grant consumes exactly one request. Back-to-back grants are allowed (one per cycle when the CPU is idle).
- Write-only cpu_stall: because the CPU is stalled in FORCE, the held CPU access re-presents next cycle in ARB and is served. No CPU access is lost.
- Reset mid-FORCE returns to ARB with the stall released immediately (asynchronously). A pending host read's rvalid is dropped.
- Worst-case host latency from host_req to host_gnt is STARVE_MAX+1 cycles.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encoding localparams ST_ARB=1'b0, ST_FORCE=1'b1
  - owner encoding OWN_NONE, OWN_CPU, OWN_HOST (2 bits)
- Sub-module starve_counter (saturating, with clear, increment and terminal-count output) instantiated once. The FSM, steering mux and rdata register stay in dmem_arbiter.

Test Plan:
- Reset, CPU idle, host read of addr 0x10 holding 0x5A -> host_gnt in the same cycle; next cycle host_rvalid=1, host_rdata=0x5A; cpu_stall never asserts.
- CPU write 0xA5 to 0x20 every cycle, host_req held for a read of 0x20, STARVE_MAX=4 -> 4 cycles with gnt=0 and mem_we from the CPU; cycle 5 has cpu_stall=1, host_gnt=1; cycle 6 has host_rdata=0xA5, CPU again owns the port, starve_cnt=0.
- Same cycle cpu_rd=1 at 0x30 and host write 0x77 to 0x30 with CPU idle next cycle -> cycle 1 mem_we=0, cpu_rdata=old value; cycle 2 host_gnt=1, mem_we=1, mem_wdata=0x77.
- Host requests 3 times, drops after 2 denied cycles, re-requests -> starve_cnt restarts from 0; FORCE occurs only after 4 further continuous denied cycles.
- Assert reset low during FORCE -> cpu_stall and host_gnt drop immediately, host_rvalid=0 after the edge, state is ARB after release.
- CPU idle, 3 consecutive host writes (0x01->0x40, 0x02->0x41, 0x03->0x42) -> 3 consecutive grants; readback returns 0x01, 0x02, 0x03 with one-cycle rvalid each.
